// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, stall-reason
// codes, the memory-wait timeout and the bundled control-output record.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'b00,
        HZ_LOAD_USE = 2'b01,
        HZ_MEM      = 2'b10
    } hz_code_e;

    localparam logic [7:0] WAIT_TIMEOUT = 8'd255;

    typedef struct packed {
        logic     combined_stall;
        hz_code_e hazard_stall;
        logic     ex_clear;
        logic     pc_write_en;
        logic     if_id_write_en;
    } ctrl_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage status in, stall/flush controls
// and performance counters out.
interface pipeline_hazard_ctrl_if;

    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_enable_out;
    logic        ID_EX_MemRead;
    logic        ID_EX_enable_out;
    logic [4:0]  ID_EX_Rd;
    logic        EX_branch_taken;
    logic        imem_ready;
    logic        dmem_ready;

    logic        combined_stall;
    logic [1:0]  hazard_stall;
    logic        EX_clear_IF_ID;
    logic        pc_write_en;
    logic        IF_ID_write_en;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output IF_ID_Instruction, IF_ID_enable_out, ID_EX_MemRead, ID_EX_enable_out,
               ID_EX_Rd, EX_branch_taken, imem_ready, dmem_ready,
        input  combined_stall, hazard_stall, EX_clear_IF_ID, pc_write_en,
               IF_ID_write_en, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_Instruction, IF_ID_enable_out, ID_EX_MemRead, ID_EX_enable_out,
               ID_EX_Rd, EX_branch_taken, imem_ready, dmem_ready,
        output combined_stall, hazard_stall, EX_clear_IF_ID, pc_write_en,
               IF_ID_write_en, mem_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a valid load in EX whose destination is a
// source of the valid instruction in ID.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        id_valid,
    input  logic        ex_mem_read,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    output logic        load_use
);

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       unused_instr_bits;

    assign rs1 = rs1_of(instruction);
    assign rs2 = rs2_of(instruction);

    // Opcode/funct/rd fields play no part in the hazard decision.
    assign unused_instr_bits = ^{instruction[31:25], instruction[14:0]};

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                      ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: memory-wait stalls, branch flushes and load-use bubbles,
// with a sticky wait timeout and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    state_e      state;
    state_e      state_next;
    state_e      eff_state;
    ctrl_t       ctrl;
    logic        load_use;
    logic        mem_busy;
    logic        pending_flush;
    logic [7:0]  wait_cnt;
    logic        mem_timeout_q;
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    hazard_detect u_hazard_detect (
        .instruction (hz.IF_ID_Instruction),
        .id_valid    (hz.IF_ID_enable_out),
        .ex_mem_read (hz.ID_EX_MemRead),
        .ex_valid    (hz.ID_EX_enable_out),
        .ex_rd       (hz.ID_EX_Rd),
        .load_use    (load_use)
    );

    assign mem_busy = !hz.imem_ready || !hz.dmem_ready;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; the reset branch is synchronous and wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_RUN;
        case (state)
            ST_RUN:      state_next = mem_busy ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT: state_next = mem_busy ? ST_MEM_WAIT : ST_RUN;
            ST_FLUSH:    state_next = mem_busy ? ST_MEM_WAIT : ST_RUN;
            default:     state_next = ST_RUN;
        endcase
    end

    // The cycle the memory wait ends already behaves as its destination state,
    // so a deferred flush is issued there, exactly once, and the FSM resumes RUN.
    always_comb begin
        eff_state = state;
        if (state == ST_MEM_WAIT && !mem_busy) begin
            eff_state = pending_flush ? ST_FLUSH : ST_RUN;
        end
    end

    always_comb begin
        ctrl = '{combined_stall: 1'b0, hazard_stall: HZ_NONE, ex_clear: 1'b0,
                 pc_write_en: 1'b0, if_id_write_en: 1'b0};
        if (reset) begin
            ctrl.pc_write_en = 1'b0;
        end else if (mem_busy) begin
            ctrl.combined_stall = 1'b1;
            ctrl.hazard_stall   = HZ_MEM;
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    ctrl.ex_clear    = 1'b1;
                    ctrl.pc_write_en = 1'b1;
                end
                ST_RUN: begin
                    if (hz.EX_branch_taken) begin
                        ctrl.ex_clear    = 1'b1;
                        ctrl.pc_write_en = 1'b1;
                    end else if (load_use) begin
                        ctrl.combined_stall = 1'b1;
                        ctrl.hazard_stall   = HZ_LOAD_USE;
                    end else begin
                        ctrl.pc_write_en    = 1'b1;
                        ctrl.if_id_write_en = 1'b1;
                    end
                end
                default: ctrl.combined_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_flush  <= 1'b0;
            wait_cnt       <= 8'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (mem_busy && hz.EX_branch_taken) begin
                pending_flush <= 1'b1;
            end else if (!mem_busy && eff_state == ST_FLUSH) begin
                pending_flush <= 1'b0;
            end

            if (mem_busy) begin
                if (state != ST_MEM_WAIT) begin
                    wait_cnt <= 8'd0;
                end else if (wait_cnt != WAIT_TIMEOUT) begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt == WAIT_TIMEOUT - 8'd1) begin
                        mem_timeout_q <= 1'b1;
                    end
                end
            end

            if (ctrl.combined_stall && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (ctrl.ex_clear && flush_count_q != 16'hFFFF) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign hz.combined_stall = ctrl.combined_stall;
    assign hz.hazard_stall   = ctrl.hazard_stall;
    assign hz.EX_clear_IF_ID = ctrl.ex_clear;
    assign hz.pc_write_en    = ctrl.pc_write_en;
    assign hz.IF_ID_write_en = ctrl.if_id_write_en;
    assign hz.mem_timeout    = mem_timeout_q;
    assign hz.stall_cycles   = stall_cycles_q;
    assign hz.flush_count    = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl, compared every cycle
// against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain booleans and integers derived from the rules.
    bit     m_waiting = 0;
    bit     m_pending = 0;
    bit     m_timeout = 0;
    int     m_wait_cycles = 0;
    longint m_stalls = 0;
    int     m_flushes = 0;

    logic       e_stall, e_clr, e_pc, e_ifid;
    logic [1:0] e_hz;
    logic       o_stall, o_clr, o_pc, o_ifid;
    logic [1:0] o_hz;

    // add x6, x5, x7 ; add x6, x0, x7 ; add x6, x8, x7 ; add x6, x7, x5
    localparam logic [31:0] ADD_6_5_7 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_6_0_7 = {7'd0, 5'd7, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_6_8_7 = {7'd0, 5'd7, 5'd8, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_6_7_5 = {7'd0, 5'd5, 5'd7, 3'd0, 5'd6, 7'b0110011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        logic busy, lu;
        logic [31:0] ins;
        ins  = bus.IF_ID_Instruction;
        busy = !(bus.imem_ready && bus.dmem_ready);
        lu   = bus.ID_EX_enable_out && bus.ID_EX_MemRead && bus.IF_ID_enable_out &&
               (bus.ID_EX_Rd != 0) &&
               (bus.ID_EX_Rd == ins[19:15] || bus.ID_EX_Rd == ins[24:20]);
        {e_stall, e_hz, e_clr, e_pc, e_ifid} = '0;
        if (reset) begin
            e_pc = 1'b0;
        end else if (busy) begin
            e_stall = 1'b1;
            e_hz    = 2'b10;
        end else if (m_pending || bus.EX_branch_taken) begin
            e_clr = 1'b1;
            e_pc  = 1'b1;
        end else if (lu) begin
            e_stall = 1'b1;
            e_hz    = 2'b01;
        end else begin
            e_pc   = 1'b1;
            e_ifid = 1'b1;
        end
    endtask

    task automatic commit();
        logic busy;
        busy = !(bus.imem_ready && bus.dmem_ready);
        if (reset) begin
            m_waiting = 0; m_pending = 0; m_timeout = 0;
            m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (busy) begin
                if (!m_waiting) begin
                    m_waiting     = 1;
                    m_wait_cycles = 0;
                end else begin
                    if (m_wait_cycles < 255) m_wait_cycles++;
                    if (m_wait_cycles == 255) m_timeout = 1;
                end
                if (bus.EX_branch_taken) m_pending = 1;
            end else begin
                m_waiting = 0;
                if (e_clr) m_pending = 0;
            end
            if (e_stall && m_stalls < 64'h0000_0000_FFFF_FFFF) m_stalls++;
            if (e_clr && m_flushes < 16'hFFFF) m_flushes++;
        end
    endtask

    // One clock: check combinational outputs mid-cycle, registered ones after the edge.
    task automatic tick(input string tag);
        @(negedge clk);
        predict();
        o_stall = bus.combined_stall;
        o_hz    = bus.hazard_stall;
        o_clr   = bus.EX_clear_IF_ID;
        o_pc    = bus.pc_write_en;
        o_ifid  = bus.IF_ID_write_en;
        check({tag, "/ctrl"}, {27'd0, o_stall, o_hz, o_clr, o_pc, o_ifid},
              {27'd0, e_stall, e_hz, e_clr, e_pc, e_ifid});
        @(posedge clk);
        commit();
        #1;
        check({tag, "/mem_timeout"}, {31'd0, bus.mem_timeout}, {31'd0, m_timeout});
        check({tag, "/stall_cycles"}, bus.stall_cycles, m_stalls[31:0]);
        check({tag, "/flush_count"}, {16'd0, bus.flush_count}, m_flushes);
    endtask

    task automatic set_idle();
        bus.IF_ID_Instruction = 32'd0;
        bus.IF_ID_enable_out  = 1'b1;
        bus.ID_EX_MemRead     = 1'b0;
        bus.ID_EX_enable_out  = 1'b0;
        bus.ID_EX_Rd          = 5'd0;
        bus.EX_branch_taken   = 1'b0;
        bus.imem_ready        = 1'b1;
        bus.dmem_ready        = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [31:0] ins);
        bus.ID_EX_enable_out  = 1'b1;
        bus.ID_EX_MemRead     = 1'b1;
        bus.ID_EX_Rd          = rd;
        bus.IF_ID_enable_out  = 1'b1;
        bus.IF_ID_Instruction = ins;
    endtask

    initial begin
        logic [31:0] rnd_ins;

        reset = 1'b1;
        set_idle();
        tick("reset0");
        tick("reset1");
        check("reset_pc_we", {31'd0, o_pc}, 32'd0);
        check("reset_ifid_we", {31'd0, o_ifid}, 32'd0);
        check("reset_stall_cnt", bus.stall_cycles, 32'd0);

        reset = 1'b0;
        tick("idle");
        check("idle_we", {30'd0, o_pc, o_ifid}, 32'd3);

        // Load-use on rs1, then the bubble the stall created.
        set_load(5'd5, ADD_6_5_7);
        tick("lu_rs1");
        check("lu_rs1_code", {29'd0, o_stall, o_hz}, {29'd0, 1'b1, 2'b01});
        check("lu_rs1_pc", {31'd0, o_pc}, 32'd0);
        bus.ID_EX_enable_out = 1'b0;
        tick("lu_bubble");
        check("lu_bubble_clear", {28'd0, o_stall, o_hz, o_pc}, 32'd1);

        // No dependency: load to x0, and unrelated sources; then rs2 match.
        set_load(5'd0, ADD_6_0_7);
        tick("lu_x0");
        check("lu_x0_nostall", {31'd0, o_stall}, 32'd0);
        set_load(5'd5, ADD_6_8_7);
        tick("lu_miss");
        check("lu_miss_nostall", {31'd0, o_stall}, 32'd0);
        set_load(5'd5, ADD_6_7_5);
        tick("lu_rs2");
        check("lu_rs2_stall", {31'd0, o_stall}, 32'd1);

        // Branch overrides a concurrent load-use.
        bus.EX_branch_taken = 1'b1;
        tick("br_lu");
        check("br_lu_clear", {30'd0, o_clr, o_stall}, 32'd2);
        check("br_lu_flushes", {16'd0, bus.flush_count}, 32'd1);

        // Three memory-wait cycles with a branch in the second, then one flush.
        reset = 1'b1; set_idle(); tick("rst_a");
        reset = 1'b0;
        bus.dmem_ready = 1'b0;
        tick("dmem_w1");
        bus.EX_branch_taken = 1'b1;
        tick("dmem_w2");
        bus.EX_branch_taken = 1'b0;
        tick("dmem_w3");
        check("dmem_w3_code", {30'd0, o_hz}, 32'd2);
        bus.dmem_ready = 1'b1;
        tick("dmem_done");
        check("dmem_flush", {29'd0, o_clr, o_pc, o_ifid}, 32'b110);
        check("dmem_stalls", bus.stall_cycles, 32'd3);
        tick("dmem_after");
        check("dmem_single_flush", {31'd0, o_clr}, 32'd0);

        // Long instruction-memory wait trips the sticky timeout.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick("imem_hold");
            if (i == 254) check("timeout_not_yet", {31'd0, bus.mem_timeout}, 32'd0);
            if (i == 255) check("timeout_set", {31'd0, bus.mem_timeout}, 32'd1);
        end
        bus.imem_ready = 1'b1;
        tick("imem_release");
        check("timeout_sticky", {31'd0, bus.mem_timeout}, 32'd1);
        reset = 1'b1;
        tick("rst_timeout");
        check("timeout_cleared", {31'd0, bus.mem_timeout}, 32'd0);
        check("counters_cleared", bus.stall_cycles | {16'd0, bus.flush_count}, 32'd0);

        // Reset during a wait with a pending flush drops the flush.
        reset = 1'b0;
        bus.dmem_ready = 1'b0;
        tick("rw_w1");
        bus.EX_branch_taken = 1'b1;
        tick("rw_w2");
        bus.EX_branch_taken = 1'b0;
        reset = 1'b1;
        tick("rw_reset");
        reset = 1'b0;
        bus.dmem_ready = 1'b1;
        tick("rw_after");
        check("rw_no_flush", {30'd0, o_clr, o_pc}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rnd_ins        = $urandom;
            rnd_ins[19:15] = 5'($urandom_range(0, 3));
            rnd_ins[24:20] = 5'($urandom_range(0, 3));
            reset                 = ($urandom_range(0, 49) == 0);
            bus.IF_ID_Instruction = rnd_ins;
            bus.IF_ID_enable_out  = ($urandom_range(0, 3) != 0);
            bus.ID_EX_enable_out  = ($urandom_range(0, 3) != 0);
            bus.ID_EX_MemRead     = ($urandom_range(0, 1) == 1);
            bus.ID_EX_Rd          = 5'($urandom_range(0, 3));
            bus.EX_branch_taken   = ($urandom_range(0, 6) == 0);
            bus.imem_ready        = ($urandom_range(0, 9) != 0);
            bus.dmem_ready        = ($urandom_range(0, 7) != 0);
            tick("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
